// File: rtl/led_cycle_if.sv
// Board-side bundle for the LED chaser: raw button pins in, LED bank out.
interface led_cycle_if;
  logic [4:0]  buttons;
  logic [15:0] led;

  modport master (output buttons, input led);
  modport slave  (input buttons, output led);
endinterface

// File: rtl/led_cycle.sv
// Single-lit LED chaser: rotates a one-hot pattern across 16 LEDs at a
// button-selected rate (highest pressed button index picks the speed).
module led_cycle #(
  parameter int DIV_SLOW   = 25_000_000,
  parameter int SHIFT_STEP = 2,
  parameter int CNT_W      = 25
) (
  input  logic        clk,
  input  logic        rst_n,  // active-high despite the name
  led_cycle_if.slave  io
);

  logic [4:0]       sync1, sync2;
  logic [2:0]       level;
  logic [CNT_W-1:0] cnt, period_m1;
  logic             step;
  logic [15:0]      led_q;
  logic             led_onehot;

  // Buttons are asynchronous board pins; only the second stage feeds logic.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= io.buttons;
      sync2 <= sync1;
    end
  end

  always_comb begin
    level = 3'd0;
    if      (sync2[4]) level = 3'd4;
    else if (sync2[3]) level = 3'd3;
    else if (sync2[2]) level = 3'd2;
    else if (sync2[1]) level = 3'd1;
  end

  always_comb begin
    period_m1 = CNT_W'(DIV_SLOW - 1);
    case (level)
      3'd1:    period_m1 = CNT_W'((DIV_SLOW >> (1 * SHIFT_STEP)) - 1);
      3'd2:    period_m1 = CNT_W'((DIV_SLOW >> (2 * SHIFT_STEP)) - 1);
      3'd3:    period_m1 = CNT_W'((DIV_SLOW >> (3 * SHIFT_STEP)) - 1);
      3'd4:    period_m1 = CNT_W'((DIV_SLOW >> (4 * SHIFT_STEP)) - 1);
      default: period_m1 = CNT_W'(DIV_SLOW - 1);
    endcase
  end

  // ">=" so a speed-up while the count is already past the new period
  // still produces a step on the next cycle instead of a counter wrap.
  assign step = (cnt >= period_m1);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)     cnt <= '0;
    else if (step) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  assign led_onehot = (led_q != '0) && ((led_q & (led_q - 16'd1)) == '0);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      led_q <= 16'h0001;
    else if (step)
      led_q <= led_onehot ? {led_q[14:0], led_q[15]} : 16'h0001;
  end

  assign io.led = led_q;

endmodule

// File: tb/tb_led_cycle.sv
// Directed bench for led_cycle with DIV_SLOW=64, SHIFT_STEP=1 (P = 64/32/16/8/4).
module tb_led_cycle;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n;

  led_cycle_if ifc ();

  led_cycle #(.DIV_SLOW(64), .SHIFT_STEP(1), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until led changes, sampling on falling edges.
  task automatic measure(input int limit, output int cycles);
    logic [15:0] prev;
    prev   = ifc.led;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (ifc.led === prev && cycles < limit);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b0) begin
      n_assert++;
      assert ($onehot(ifc.led) === 1'b1) else begin
        n_fail++;
        $error("FAIL onehot: observed %0h expected one-hot", ifc.led);
      end
    end
  end

  initial begin
    logic [15:0] exp_led;
    ifc.buttons = 5'b00000;
    rst_n       = 1'b1;

    // 1: reset, then slowest rate with no buttons
    repeat (5) @(negedge clk);
    check("reset_led", 32'(ifc.led), 32'h0001);
    rst_n = 1'b0;
    measure(200, n);
    check("first_step_cycles", n, 64);
    check("first_step_led", 32'(ifc.led), 32'h0002);
    measure(200, n);
    check("l0_interval", n, 64);
    check("l0_led", 32'(ifc.led), 32'h0004);

    // 2: button 0 alone behaves like no button
    ifc.buttons = 5'b00001;
    for (int i = 0; i < 2; i++) begin
      measure(200, n);
      check("btn0_interval", n, 64);
    end

    // 3: each higher button in turn
    ifc.buttons = 5'b00010;
    for (int i = 0; i < 3; i++) begin measure(200, n); check("l1_interval", n, 32); end
    ifc.buttons = 5'b00100;
    for (int i = 0; i < 3; i++) begin measure(200, n); check("l2_interval", n, 16); end
    ifc.buttons = 5'b01000;
    for (int i = 0; i < 3; i++) begin measure(200, n); check("l3_interval", n, 8); end
    ifc.buttons = 5'b10000;
    for (int i = 0; i < 3; i++) begin measure(200, n); check("l4_interval", n, 4); end

    // 4: priority - highest pressed index wins
    ifc.buttons = 5'b00010;
    measure(200, n);
    check("l1_again", n, 32);
    ifc.buttons = 5'b10110;
    for (int i = 0; i < 3; i++) begin measure(200, n); check("prio_interval", n, 4); end

    // 5: full rotation from reset at the fastest rate
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rerst_led", 32'(ifc.led), 32'h0001);
    ifc.buttons = 5'b10000;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      measure(20, n);
      exp_led = 16'h0001 << (i % 16);
      check("rot_interval", n, 4);
      check("rot_led", 32'(ifc.led), 32'(exp_led));
    end

    // 6: speed-up while count is past the new period
    ifc.buttons = 5'b00000;
    repeat (45) @(negedge clk);
    check("hold_l0_led", 32'(ifc.led), 32'h0001);
    ifc.buttons = 5'b10000;
    measure(20, n);
    check("speedup_latency", n, 3);
    check("speedup_led", 32'(ifc.led), 32'h0002);
    repeat (2) @(negedge clk);
    check("pre_rst_led", 32'(ifc.led), 32'h0002);
    #2 rst_n = 1'b1;
    #1 check("async_rst_led", 32'(ifc.led), 32'h0001);
    ifc.buttons = 5'b00000;
    @(negedge clk);
    rst_n = 1'b0;
    measure(200, n);
    check("post_rst_cycles", n, 64);
    check("post_rst_led", 32'(ifc.led), 32'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
